// File: rtl/pc_sequencer.sv
// Fetch-side PC controller: chooses the PC register's next value and enable, and raises the
// IF/ID and ID/EX flush strobes for boot, redirects, stalls, freezes and EBREAK halt/resume.
module pc_sequencer #(
    parameter int               PC_W     = 13,
    parameter logic [PC_W-1:0]  RESET_PC = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [PC_W-1:0]  pc,
    input  logic             stall,
    input  logic             freeze,
    input  logic             br_taken,
    input  logic [PC_W-1:0]  br_target,
    input  logic             halt_req,
    input  logic             resume,
    output logic [PC_W-1:0]  next_pc,
    output logic             pc_en,
    output logic             flush_if_id,
    output logic             flush_id_ex,
    output logic             halted,
    output logic             misalign_err
);

    typedef enum logic [1:0] {
        ST_RESET = 2'd0,
        ST_BOOT  = 2'd1,
        ST_RUN   = 2'd2,
        ST_HALT  = 2'd3
    } state_t;

    localparam logic [PC_W-1:0] PC_STEP    = PC_W'(4);
    localparam logic [PC_W-1:0] ALIGN_MASK = ~PC_W'(3);

    state_t            state_q, state_d;
    logic              pend_vld_q, pend_vld_d;
    logic              pend_halt_q, pend_halt_d;
    logic [PC_W-1:0]   pend_tgt_q, pend_tgt_d;
    logic [PC_W-1:0]   pc_inc;
    logic [PC_W-1:0]   redir_tgt;

    function automatic logic [PC_W-1:0] word_align(input logic [PC_W-1:0] addr);
        return addr & ALIGN_MASK;
    endfunction

    // Sequential increment wraps naturally at PC_W bits.
    assign pc_inc    = pc + PC_STEP;
    assign redir_tgt = br_taken ? br_target : pend_tgt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_RESET;
            pend_vld_q  <= 1'b0;
            pend_halt_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            pend_vld_q  <= pend_vld_d;
            pend_halt_q <= pend_halt_d;
        end
    end

    // Target is qualified by pend_vld_q, so it needs no reset.
    always_ff @(posedge clk) begin
        pend_tgt_q <= pend_tgt_d;
    end

    always_comb begin
        state_d      = state_q;
        pend_vld_d   = pend_vld_q;
        pend_halt_d  = pend_halt_q;
        pend_tgt_d   = pend_tgt_q;
        next_pc      = pc_inc;
        pc_en        = 1'b0;
        flush_if_id  = 1'b0;
        flush_id_ex  = 1'b0;
        halted       = 1'b0;
        misalign_err = 1'b0;

        unique case (state_q)
            ST_RESET: begin
                next_pc     = RESET_PC;
                flush_if_id = 1'b1;
                flush_id_ex = 1'b1;
                pend_vld_d  = 1'b0;
                pend_halt_d = 1'b0;
                state_d     = ST_BOOT;
            end
            ST_BOOT: begin
                pc_en       = 1'b1;
                next_pc     = RESET_PC;
                flush_if_id = 1'b1;
                flush_id_ex = 1'b1;
                state_d     = ST_RUN;
            end
            ST_RUN: begin
                if (freeze) begin
                    // Events arriving while EX is busy are parked until it frees up.
                    if (br_taken) begin
                        pend_vld_d = 1'b1;
                        pend_tgt_d = br_target;
                    end
                    if (halt_req) begin
                        pend_halt_d = 1'b1;
                    end
                end else if (halt_req || pend_halt_q) begin
                    flush_if_id = 1'b1;
                    flush_id_ex = 1'b1;
                    pend_vld_d  = 1'b0;
                    pend_halt_d = 1'b0;
                    state_d     = ST_HALT;
                end else if (br_taken || pend_vld_q) begin
                    pc_en        = 1'b1;
                    next_pc      = word_align(redir_tgt);
                    flush_if_id  = 1'b1;
                    flush_id_ex  = 1'b1;
                    misalign_err = redir_tgt[1];
                    pend_vld_d   = 1'b0;
                end else if (stall) begin
                    flush_id_ex = 1'b1;
                end else begin
                    pc_en = 1'b1;
                end
            end
            ST_HALT: begin
                flush_if_id = 1'b1;
                halted      = 1'b1;
                // A coincident reset takes precedence, so the PC must not advance.
                if (resume && !rst) begin
                    pc_en   = 1'b1;
                    state_d = ST_RUN;
                end
            end
            default: begin
                state_d = ST_RESET;
            end
        endcase
    end

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Fetch-side controller that drives the PC register's `next_pc` and enable inputs in the RV32IM pipeline. It sequences boot, sequential fetch, EX-stage branch/jump redirects, hazard stalls, multi-cycle freezes (M-extension divide) and EBREAK halt/resume. It also generates the IF/ID and ID/EX flush strobes. It sits between the hazard unit, the EX stage and the PC register, and owns every PC update decision.

## Interface
Parameters:
- `PC_W`, 13: PC width in bits; matches the PC register.
- `RESET_PC`, 0: first fetch address after reset; must be word aligned.

Ports:
- `clk`  in  1  clock; all state updates on rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `pc`  in  PC_W  current PC from the PC register.
- `stall`  in  1  hazard-unit load-use stall; hold PC and IF/ID.
- `freeze`  in  1  multi-cycle EX unit busy; whole front end holds.
- `br_taken`  in  1  single-cycle pulse from EX: taken branch or JAL/JALR.
- `br_target`  in  PC_W  redirect address; valid with `br_taken`.
- `halt_req`  in  1  EBREAK retired in EX; single-cycle pulse.
- `resume`  in  1  debug resume pulse; honoured only in HALT.
- `next_pc`  out  PC_W  address loaded into the PC register when `pc_en`=1.
- `pc_en`  out  1  PC register enable.
- `flush_if_id`  out  1  squash the IF/ID register this cycle.
- `flush_id_ex`  out  1  squash the ID/EX register this cycle.
- `halted`  out  1  high while in HALT.
- `misalign_err`  out  1  one-cycle pulse: the redirect target had bit 1 set.

## Operation
- States: RESET, BOOT, RUN, HALT. State is registered. Outputs are combinational from state, the pending register and inputs.
- RESET (entered whenever `rst`=1, from any state; pending redirect cleared):
  - `pc_en`=0, `next_pc`=RESET_PC, both flushes=1, `halted`=0, `misalign_err`=0.
  - Always transitions to BOOT on the first edge with `rst`=0.
- BOOT (exactly one cycle):
  - `pc_en`=1, `next_pc`=RESET_PC, both flushes=1.
  - Transitions to RUN.
- RUN, priority highest first:
  1. `freeze`: `pc_en`=0, no flush. A `br_taken` arriving during freeze is captured into a pending register (target + valid). A `halt_req` during freeze is captured into a pending-halt bit.
  2. `halt_req` or pending-halt: `pc_en`=0, both flushes=1, transition to HALT. Any pending redirect is discarded.
  3. `br_taken` or pending redirect: `pc_en`=1, `next_pc`={target[PC_W-1:2],2'b00}, both flushes=1. This wins over `stall`. Pending is cleared. A live `br_taken` beats a pending redirect.
  4. `stall`: `pc_en`=0, `flush_id_ex`=1 (bubble), `flush_if_id`=0.
  5. Otherwise: `pc_en`=1, `next_pc`=`pc`+4, truncated to PC_W bits (wraps modulo 2^PC_W), no flush.
- `misalign_err`: pulses in the cycle a redirect is applied with target bit 1 = 1. Target bit 0 is ignored silently.
- HALT:
  - `pc_en`=0, `flush_if_id`=1, `halted`=1. `br_taken`, `stall` and `freeze` are ignored.
  - On `resume`: `pc_en`=1, `next_pc`=`pc`+4, transition to RUN.
  - `halt_req` while already in HALT has no effect.

## Timing
- `next_pc`/`pc_en` are combinational; the PC register updates on the same edge. Redirect latency: `pc`=target one cycle after the `br_taken` cycle.
- First fetch: `pc`=RESET_PC on the edge that ends BOOT. Fetch at RESET_PC+4 follows the next cycle.
- Pending redirect is applied in the first RUN cycle with `freeze`=0. Latency is one cycle after `freeze` falls.
- `rst` asserted mid-redirect or in HALT takes effect at the next edge. No pending state survives it.
- `resume` and `rst` in the same cycle: `rst` wins.
- `halt_req` and `br_taken` in the same cycle: halt wins. The redirect is dropped and `pc` is unchanged.

## Test plan
- Reset release: `rst`=1 for 3 cycles, then 0. Required: BOOT for one cycle, then `pc`=0x000, 0x004, 0x008 on successive cycles. Flushes are high during RESET and BOOT only.
- Branch during stall: `pc`=0x010, `stall`=1 and `br_taken`=1 with `br_target`=0x100. Required: next `pc`=0x100, both flushes high that cycle, `misalign_err`=0.
- Freeze capture: `freeze`=1 for 4 cycles with a `br_taken` pulse (target 0x0A6) in cycle 2. Required: `pc` holds for all 4 cycles. On the first unfrozen cycle `next_pc`=0x0A4 and `misalign_err`=1.
- Wrap: `pc`=0x1FFC (PC_W=13) with no events. Required: `next_pc`=0x0000.
- Halt/resume: `halt_req` at `pc`=0x040. Required: `halted`=1 and `pc` holds at 0x040 for 10 cycles, including a `br_taken` pulse that must be ignored. After `resume`: `pc`=0x044 and `halted`=0.
- Reset in HALT: `rst` pulsed for one cycle while halted. Required: `halted`=0 next cycle, followed by the BOOT sequence to RESET_PC.
